ifu_prefetch: RTL and testbench

IFU_PREFETCH -- requirements
Module: ifu_prefetch

---
 rtl/ifu_prefetch_if.sv | 29 ++
 rtl/ifu_prefetch.sv | 114 +++++++++++
 tb/tb_ifu_prefetch.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_prefetch_if.sv
// Handshake bundle between the prefetch unit, instruction memory, decode and
// the branch-redirect source.
interface ifu_prefetch_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [CPU_WIDTH-1:0] imem_req_addr;
  logic                 imem_rsp_valid;
  logic [CPU_WIDTH-1:0] imem_rsp_data;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [CPU_WIDTH-1:0] inst;
  logic [CPU_WIDTH-1:0] inst_pc;
  logic                 redirect_valid;
  logic [CPU_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: sequential fetch, in-order response FIFO, redirect flush
// with stale-response dropping. Define IFU_BYPASS_EN for empty-FIFO response bypass.
module ifu_prefetch #(
  parameter int                   CPU_WIDTH = 32,
  parameter int                   DEPTH     = 4,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = '0
) (
  input logic             clk,
  input logic             rst,
  ifu_prefetch_if.master  io_bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = CNT_W + 2;
  localparam logic [CPU_WIDTH-1:0] ALIGN_MASK = ~CPU_WIDTH'(3);
  localparam logic [CPU_WIDTH-1:0] START_PC   = RESET_PC & ALIGN_MASK;

  logic [CPU_WIDTH-1:0] r_instMem [DEPTH];
  logic [CPU_WIDTH-1:0] r_pcMem   [DEPTH];
  logic [PTR_W-1:0]     r_wrPtr;
  logic [PTR_W-1:0]     r_rdPtr;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     r_outstanding;
  logic [CNT_W-1:0]     r_drop;
  logic [CPU_WIDTH-1:0] r_fetchPc;
  logic [CPU_WIDTH-1:0] r_expPc;

  logic [SUM_W-1:0]     w_sum;
  logic                 w_redirect;
  logic                 w_reqValid;
  logic                 w_accept;
  logic                 w_rspDrop;
  logic                 w_rspLive;
  logic                 w_fifoEmpty;
  logic                 w_bypass;
  logic                 w_instValid;
  logic                 w_pop;
  logic                 w_push;
  logic [CPU_WIDTH-1:0] w_redirPc;

  // Stale requests still in flight count against capacity, so a live
  // response always has a FIFO slot waiting for it.
  assign w_sum = SUM_W'(r_count) + SUM_W'(r_outstanding) + SUM_W'(r_drop);
  assign w_redirect  = io_bus.redirect_valid;
  assign w_redirPc   = io_bus.redirect_pc & ALIGN_MASK;
  assign w_reqValid  = !rst && !w_redirect && (w_sum < SUM_W'(DEPTH));
  assign w_accept    = w_reqValid && io_bus.imem_req_ready;
  assign w_rspDrop   = io_bus.imem_rsp_valid && ((r_drop != '0) || w_redirect);
  assign w_rspLive   = io_bus.imem_rsp_valid && !w_rspDrop;
  assign w_fifoEmpty = (r_count == '0);

`ifdef IFU_BYPASS_EN
  assign w_bypass = w_fifoEmpty && w_rspLive;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_instValid = !rst && !w_redirect && (!w_fifoEmpty || w_bypass);
  assign w_pop       = w_instValid && io_bus.inst_ready && !w_fifoEmpty;
  assign w_push      = w_rspLive && !(w_bypass && io_bus.inst_ready);

  assign io_bus.imem_req_valid = w_reqValid;
  assign io_bus.imem_req_addr  = r_fetchPc;
  assign io_bus.inst_valid     = w_instValid;
  assign io_bus.inst    = w_fifoEmpty ? io_bus.imem_rsp_data : r_instMem[r_rdPtr];
  assign io_bus.inst_pc = w_fifoEmpty ? r_expPc : r_pcMem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instMem[r_wrPtr] <= io_bus.imem_rsp_data;
      r_pcMem[r_wrPtr]   <= r_expPc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_fetchPc     <= START_PC;
      r_expPc       <= START_PC;
    end else if (w_redirect) begin
      // Everything in flight becomes stale; a response landing now retires one of them.
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= r_drop + r_outstanding + CNT_W'(w_accept)
                       - CNT_W'(io_bus.imem_rsp_valid);
      r_fetchPc     <= w_redirPc;
      r_expPc       <= w_redirPc;
    end else begin
      if (w_accept) begin
        r_fetchPc <= r_fetchPc + CPU_WIDTH'(4);
      end
      if (w_rspDrop) begin
        r_drop <= r_drop - CNT_W'(1);
      end
      if (w_rspLive) begin
        r_expPc <= r_expPc + CPU_WIDTH'(4);
      end
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rspLive);
      r_count       <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: vector table for the fill/stream phase,
// directed sequences for stall, redirect, back-to-back redirect and PC wrap.
module tb_ifu_prefetch;
  localparam int          W     = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] MAGIC = 32'hDEAD_0000;

  typedef struct {
    logic        reqReady;
    logic        instReady;
    logic        expReqValid;
    logic [31:0] expReqAddr;
    logic        expInstValid;
    logic [31:0] expInstPc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  logic clk = 1'b0;
  logic rst;

  ifu_prefetch_if #(.CPU_WIDTH(W)) bus ();

  ifu_prefetch #(
    .CPU_WIDTH (W),
    .DEPTH     (DEPTH),
    .RESET_PC  (32'h0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  vec_t        vecs [10];
  memReq_t     memQ [$];
  int          cyc;
  int          latency;
  int          nChecks;
  int          nErrors;
  int          delivered;
  int          accepts;
  logic [31:0] expNext;
  logic [31:0] firstPc;
  bit          haveFirst;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled 2ns later.
  task automatic applyStimulus(input logic reqReady, input logic instReady,
                               input logic redirect, input logic [31:0] redirPc);
    bus.imem_req_ready = reqReady;
    bus.inst_ready     = instReady;
    bus.redirect_valid = redirect;
    bus.redirect_pc    = redirPc;
    #2;
  endtask

  // Memory model plus in-order delivery scoreboard, then one clock edge.
  task automatic advance();
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      memQ.push_back('{bus.imem_req_addr, cyc + latency});
      accepts++;
    end
    if (bus.inst_valid && bus.inst_ready) begin
      checkOutput("deliverPc", bus.inst_pc, expNext);
      checkOutput("deliverData", bus.inst, expNext ^ MAGIC);
      if (!haveFirst) begin
        firstPc   = bus.inst_pc;
        haveFirst = 1'b1;
      end
      delivered++;
      expNext = expNext + 32'd4;
    end
    if (bus.redirect_valid) begin
      expNext = bus.redirect_pc & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      memReq_t r;
      r = memQ.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = r.addr ^ MAGIC;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    memQ.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rstReqValid", 32'(bus.imem_req_valid), 32'd0);
    checkOutput("rstInstValid", 32'(bus.inst_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    cyc       = 0;
    expNext   = 32'h0;
    haveFirst = 1'b0;
    delivered = 0;
    accepts   = 0;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      advance();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nChecks = 0;
    nErrors = 0;
    latency = 1;
    rst     = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;

    // Latency-1 memory streaming from reset, one request stall at cycle 7.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h18};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 32'h00};
`ifdef IFU_BYPASS_EN
    // Responses reach decode in their own cycle when the FIFO is empty.
    vecs[1].expInstValid = 1'b1; vecs[1].expInstPc = 32'h00;
    vecs[2].expInstPc = 32'h04;
    vecs[3].expInstPc = 32'h08;
    vecs[4].expInstPc = 32'h0C;
    vecs[5].expInstPc = 32'h10;
    vecs[6].expInstPc = 32'h14;
    vecs[7].expInstPc = 32'h18;
    vecs[8].expInstValid = 1'b0; vecs[8].expInstPc = 32'h00;
    vecs[9].expInstValid = 1'b1; vecs[9].expInstPc = 32'h1C;
`endif

    $display("[TB] stream from reset");
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].reqReady, vecs[i].instReady, 1'b0, 32'h0);
      checkOutput($sformatf("vec%0d.reqValid", i), 32'(bus.imem_req_valid),
                  32'(vecs[i].expReqValid));
      checkOutput($sformatf("vec%0d.reqAddr", i), bus.imem_req_addr, vecs[i].expReqAddr);
      checkOutput($sformatf("vec%0d.instValid", i), 32'(bus.inst_valid),
                  32'(vecs[i].expInstValid));
      if (vecs[i].expInstValid) begin
        checkOutput($sformatf("vec%0d.instPc", i), bus.inst_pc, vecs[i].expInstPc);
        checkOutput($sformatf("vec%0d.inst", i), bus.inst, vecs[i].expInstPc ^ MAGIC);
      end
      advance();
    end

    $display("[TB] decode stall fills the buffer");
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      advance();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("stallAccepts", 32'(accepts), 32'd4);
    checkOutput("stallReqValid", 32'(bus.imem_req_valid), 32'd0);
    checkOutput("stallInstValid", 32'(bus.inst_valid), 32'd1);
    runCycles(20);
    checkOutput("stallFirstPc", firstPc, 32'h0);
    checkOutput("stallResume", 32'(delivered >= 12), 32'd1);

    $display("[TB] redirect with three outstanding, latency 3");
    latency = 3;
    doReset();
    runCycles(3);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h103);
    checkOutput("redirInstValid", 32'(bus.inst_valid), 32'd0);
    checkOutput("redirReqValid", 32'(bus.imem_req_valid), 32'd0);
    advance();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redirNextValid", 32'(bus.imem_req_valid), 32'd1);
    checkOutput("redirNextAddr", bus.imem_req_addr, 32'h100);
    advance();
    runCycles(15);
    checkOutput("redirFirstPc", firstPc, 32'h100);
    checkOutput("redirDelivered", 32'(delivered >= 4), 32'd1);

    $display("[TB] back-to-back redirects, latency 2");
    latency = 2;
    doReset();
    runCycles(6);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
    checkOutput("b2bRspInFlight", 32'(bus.imem_rsp_valid), 32'd1);
    checkOutput("b2bInstValid", 32'(bus.inst_valid), 32'd0);
    advance();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h306);
    checkOutput("b2bReqValid", 32'(bus.imem_req_valid), 32'd0);
    advance();
    haveFirst = 1'b0;
    delivered = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("b2bNextAddr", bus.imem_req_addr, 32'h304);
    advance();
    runCycles(15);
    checkOutput("b2bFirstPc", firstPc, 32'h304);
    checkOutput("b2bDelivered", 32'(delivered >= 5), 32'd1);

    $display("[TB] fetch address wrap");
    latency = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    advance();
    haveFirst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrapValid", 32'(bus.imem_req_valid), 32'd1);
    checkOutput("wrapAddrLast", bus.imem_req_addr, 32'hFFFF_FFFC);
    advance();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrapAddrZero", bus.imem_req_addr, 32'h0000_0000);
    advance();
    runCycles(8);
    checkOutput("wrapFirstPc", firstPc, 32'hFFFF_FFFC);

    $display("[TB] reset during traffic");
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("postRstAddr", bus.imem_req_addr, 32'h0);
    checkOutput("postRstValid", 32'(bus.imem_req_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
